// File: rtl/cd_rx_pkg.sv
// Shared types and constants for the rx frame assembler.
package cd_rx_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2
  } rx_state_e;

  localparam logic [1:0] ERR_INCOMPLETE = 2'd0;
  localparam logic [1:0] ERR_CRC        = 2'd1;
  localparam logic [1:0] ERR_LEN        = 2'd2;

  localparam int unsigned HDR_SRC = 0;
  localparam int unsigned HDR_DST = 1;
  localparam int unsigned HDR_LEN = 2;

endpackage

// File: rtl/cd_rx_addr_filter.sv
// Combinational destination match: own address, broadcast, promiscuous
// mode, or any enabled multicast entry.
module cd_rx_addr_filter
  import cd_rx_pkg::*;
#(
  parameter int unsigned MCAST_N = 2
) (
  input  logic [7:0]           i_dst,
  input  logic [7:0]           i_filter,
  input  logic [8*MCAST_N-1:0] i_mc,
  input  logic [MCAST_N-1:0]   i_mc_en,
  output logic                 o_match
);

  always_comb begin
    o_match = (i_dst == i_filter) || (i_dst == 8'hff) || (i_filter == 8'hff);
    for (int unsigned i = 0; i < MCAST_N; i++) begin
      if (i_mc_en[i] && (i_mc[8*i +: 8] == i_dst)) o_match = 1'b1;
    end
  end

endmodule

// File: rtl/cd_rx_frame.sv
// Receive-frame assembler: filters, writes bytes to RAM, checks length/CRC.
// Optional statistics counters when CD_RX_STAT_EN is defined.
module cd_rx_frame
  import cd_rx_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 253,
  parameter  int unsigned MCAST_N = 2,
  localparam int unsigned AW      = $clog2(MAX_LEN + 5)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           filter,
  input  logic [8*MCAST_N-1:0] filter_mc,
  input  logic [MCAST_N-1:0]   filter_mc_en,
  input  logic                 user_crc,
  input  logic                 not_drop,
  input  logic                 abort,
  output logic                 error,
  output logic [1:0]           err_code,
  input  logic                 des_bus_idle,
  input  logic [7:0]           des_data,
  input  logic [15:0]          des_crc_data,
  input  logic                 des_data_clk,
  output logic                 des_force_wait_idle,
  output logic [7:0]           ram_wr_byte,
  output logic [AW-1:0]        ram_wr_addr,
  output logic                 ram_wr_en,
  output logic [AW-1:0]        ram_wr_len,
  output logic                 ram_switch
`ifdef CD_RX_STAT_EN
  ,
  input  logic                 stat_clr,
  output logic [15:0]          stat_ok,
  output logic [15:0]          stat_err,
  output logic [15:0]          stat_drop
`endif
);

  rx_state_e     r_state;
  logic [AW:0]   r_cnt;
  logic [7:0]    r_len;
  logic          r_error;
  logic [1:0]    r_err_code;
  logic          r_switch;
  logic          r_fwi;
  logic [7:0]    r_wr_byte;
  logic [AW-1:0] r_wr_addr;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_len;
`ifdef CD_RX_STAT_EN
  logic          r_drop;
`endif

  logic          w_dst_match;
  logic [AW:0]   w_cnt_inc;
  logic          w_last;

  cd_rx_addr_filter #(.MCAST_N(MCAST_N)) u_filter (
    .i_dst    (des_data),
    .i_filter (filter),
    .i_mc     (filter_mc),
    .i_mc_en  (filter_mc_en),
    .o_match  (w_dst_match)
  );

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_last    = (16'(r_cnt) == (16'(r_len) + 16'd4));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= SYNC;
      r_cnt      <= '0;
      r_len      <= '0;
      r_error    <= 1'b0;
      r_err_code <= '0;
      r_switch   <= 1'b0;
      r_fwi      <= 1'b0;
      r_wr_byte  <= '0;
      r_wr_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_len   <= '0;
`ifdef CD_RX_STAT_EN
      r_drop     <= 1'b0;
`endif
    end else begin
      r_error  <= 1'b0;
      r_switch <= 1'b0;
      r_wr_en  <= 1'b0;
      r_fwi    <= 1'b0;
`ifdef CD_RX_STAT_EN
      r_drop   <= 1'b0;
`endif
      case (r_state)
        SYNC: begin
          r_fwi   <= !des_bus_idle;
          r_cnt   <= '0;
          r_len   <= '0;
          r_state <= RECV;
        end
        RECV: begin
          // Idle takes priority over a coincident byte strobe.
          if (des_bus_idle) begin
            if (r_cnt >= (AW+1)'(2)) begin
              r_error    <= 1'b1;
              r_err_code <= ERR_INCOMPLETE;
              r_switch   <= not_drop;
              r_wr_len   <= not_drop ? AW'(r_cnt) : AW'(r_len);
              r_state    <= SYNC;
            end else if (r_cnt == (AW+1)'(1)) begin
              r_state <= SYNC;
            end
          end else if (des_data_clk) begin
            if (!r_cnt[AW]) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_cnt[AW-1:0];
              r_wr_byte <= des_data;
            end
            r_cnt <= w_cnt_inc;
            if (r_cnt == (AW+1)'(HDR_SRC)) begin
              if (des_data == filter && filter != 8'hff) begin
                r_state <= FLUSH;
`ifdef CD_RX_STAT_EN
                r_drop  <= 1'b1;
`endif
              end
            end else if (r_cnt == (AW+1)'(HDR_DST)) begin
              if (!w_dst_match) begin
                r_state <= FLUSH;
`ifdef CD_RX_STAT_EN
                r_drop  <= 1'b1;
`endif
              end
            end else if (r_cnt == (AW+1)'(HDR_LEN)) begin
              r_len <= des_data;
              if (32'(des_data) > MAX_LEN) begin
                r_error    <= 1'b1;
                r_err_code <= ERR_LEN;
                r_switch   <= not_drop;
                r_wr_len   <= not_drop ? AW'(HDR_LEN + 1) : AW'(des_data);
                r_state    <= FLUSH;
              end
            end else if (w_last) begin
              if (des_crc_data == 16'h0000 || user_crc) begin
                r_switch <= 1'b1;
              end else begin
                r_error    <= 1'b1;
                r_err_code <= ERR_CRC;
                r_switch   <= not_drop;
              end
              r_wr_len <= not_drop ? AW'(r_cnt + 1'b1) : AW'(r_len);
              r_state  <= SYNC;
            end
          end
        end
        FLUSH: begin
          if (des_bus_idle) r_state <= SYNC;
        end
        default: r_state <= SYNC;
      endcase
      // Abort overrides any handover decided in this cycle, including length.
      if (abort) begin
        r_state  <= SYNC;
        r_error  <= 1'b0;
        r_switch <= 1'b0;
        r_wr_len <= r_wr_len;
`ifdef CD_RX_STAT_EN
        r_drop   <= 1'b0;
`endif
      end
    end
  end

  assign error               = r_error;
  assign err_code            = r_err_code;
  assign ram_switch          = r_switch;
  assign des_force_wait_idle = r_fwi;
  assign ram_wr_byte         = r_wr_byte;
  assign ram_wr_addr         = r_wr_addr;
  assign ram_wr_en           = r_wr_en;
  assign ram_wr_len          = r_wr_len;

`ifdef CD_RX_STAT_EN
  logic [15:0] r_stat_ok, r_stat_err, r_stat_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_ok   <= '0;
      r_stat_err  <= '0;
      r_stat_drop <= '0;
    end else if (stat_clr) begin
      r_stat_ok   <= '0;
      r_stat_err  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (r_switch && !r_error && r_stat_ok != '1) r_stat_ok <= r_stat_ok + 1'b1;
      if (r_error && r_stat_err != '1)             r_stat_err <= r_stat_err + 1'b1;
      if (r_drop && r_stat_drop != '1)             r_stat_drop <= r_stat_drop + 1'b1;
    end
  end

  assign stat_ok   = r_stat_ok;
  assign stat_err  = r_stat_err;
  assign stat_drop = r_stat_drop;
`endif

endmodule
